// File: rtl/hex_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hex_write_arbiter_pkg
//   Shared definitions for the HEX display write arbiter: the FSM state
//   encoding, default parameter values and a small index-width helper.
//   No ports; imported by the interface, the arbiter top and its sub-module.
// -----------------------------------------------------------------------------
package hex_write_arbiter_pkg;

    // Default number of display requesters (clock, chrono and alarm modes).
    localparam int DEF_NUM_REQ = 3;

    // Default width of the display word written to the HEX PIO.
    localparam int DEF_DATA_W  = 16;

    // Default number of stalled cycles tolerated before a write is aborted.
    localparam int DEF_TIMEOUT = 255;

    // Width of the Avalon-MM data and address buses on the PIO side.
    localparam int AVM_DATA_W  = 32;
    localparam int AVM_ADDR_W  = 2;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_t;

    // Width needed to index n requesters; a single requester still gets one
    // bit so that index registers never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// hex_write_arbiter_if
//   Bundles the requester handshake and the Avalon-MM master bus of the HEX
//   write arbiter.
//   Signals:
//     req             per-requester write request (level, held until ack)
//     req_data        per-requester display word, slice i belongs to req[i]
//     ack             one-cycle completion pulse to the granted requester
//     avm_address     Avalon-MM address (always 0)
//     avm_chipselect  Avalon-MM chipselect
//     avm_write_n     Avalon-MM write strobe, active low
//     avm_writedata   zero-extended display word
//     avm_waitrequest slave stall
//   Modports:
//     master  the arbiter's view (drives ack and the Avalon-MM outputs)
//     slave   the environment's view (requesters plus the PIO slave)
// -----------------------------------------------------------------------------
interface hex_write_arbiter_if
    import hex_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;

    logic [AVM_ADDR_W-1:0]     avm_address;
    logic                      avm_chipselect;
    logic                      avm_write_n;
    logic [AVM_DATA_W-1:0]     avm_writedata;
    logic                      avm_waitrequest;

    modport master (
        input  req,
        input  req_data,
        output ack,
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        output req,
        output req_data,
        input  ack,
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_waitrequest
    );

endinterface

// File: rtl/hex_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin selector. The search starts at
//   (last_grant + 1) mod NUM_REQ and wraps; last_grant itself has the lowest
//   priority.
//   Ports:
//     req          in   NUM_REQ  request vector
//     last_grant   in   IDX_W    index granted most recently
//     grant        out  IDX_W    selected index (0 when nothing is requested)
//     grant_valid  out  1        high when at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               grant_valid
);

    // Walk the priority order from the farthest position (last_grant itself)
    // to the nearest (last_grant + 1); later hits overwrite earlier ones, so
    // the nearest active requester ends up selected. Only constant indices
    // are used into req, keeping the logic a flat mux tree.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && (((int'(last_grant) + k) % NUM_REQ) == i)) begin
                    grant       = IDX_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hex_write_arbiter.sv
// -----------------------------------------------------------------------------
// hex_write_arbiter
//   Arbitrates display-word writes from several clock modes onto a single
//   Avalon-MM HEX PIO. One request is served per transaction in round-robin
//   order; a word equal to the last successfully written one can be
//   acknowledged without touching the bus (SKIP_SAME). A stalled write is
//   abandoned after TIMEOUT waitrequest cycles and flagged in err_timeout.
//   Ports:
//     clk          in   1  single clock, rising edge
//     reset        in   1  synchronous, active-high reset
//     bus          --      hex_write_arbiter_if.master (requesters + Avalon-MM)
//     busy         out  1  high whenever the FSM is not in IDLE
//     err_timeout  out  1  sticky flag, set when a write is aborted
// -----------------------------------------------------------------------------
module hex_write_arbiter
    import hex_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int SKIP_SAME = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    hex_write_arbiter_if.master  bus,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int IDX_W = idx_width(NUM_REQ);

    // The stall counter only has to reach TIMEOUT-1 before the abort fires.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t         state_q;
    arb_state_t         state_d;

    logic [IDX_W-1:0]   last_grant_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  shadow_q;
    logic               shadow_valid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               err_q;

    logic [IDX_W-1:0]   rr_grant;
    logic               rr_valid;
    logic [DATA_W-1:0]  sel_data;

    logic               load_grant;
    logic               shadow_upd;
    logic               timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (bus.req),
        .last_grant  (last_grant_q),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Pick the display word belonging to the requester the arbiter selected.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_grant == IDX_W'(i)) begin
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic and all outputs. The bus is driven purely from the
    // registered state, so address/data/strobes stay stable for the whole
    // WRITE state no matter how long the slave stalls. The grant register
    // last_grant_q doubles as the index of the transaction in flight, since
    // no new grant is taken until the FSM is back in IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_grant  = 1'b0;
        shadow_upd  = 1'b0;
        timeout_hit = 1'b0;

        bus.ack            = '0;
        bus.avm_address    = '0;
        bus.avm_chipselect = 1'b0;
        bus.avm_write_n    = 1'b1;
        bus.avm_writedata  = '0;
        busy               = (state_q != ST_IDLE);
        err_timeout        = err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rr_valid) begin
                    load_grant = 1'b1;
                    if ((SKIP_SAME != 0) && shadow_valid_q && (sel_data == shadow_q)) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_write_n    = 1'b0;
                bus.avm_writedata  = AVM_DATA_W'(data_q);
                if (!bus.avm_waitrequest) begin
                    shadow_upd = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_ACK;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled cycle: give up the bus
                    // and leave the shadow alone so a retry is not skipped.
                    timeout_hit = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_ACK: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    bus.ack[i] = (last_grant_q == IDX_W'(i));
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset parks last_grant on the final
    // index so the very first grant after reset starts at requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            last_grant_q   <= IDX_W'(NUM_REQ - 1);
            data_q         <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_grant) begin
                last_grant_q <= rr_grant;
                data_q       <= sel_data;
            end
            if (shadow_upd) begin
                shadow_q       <= data_q;
                shadow_valid_q <= 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hex_write_arbiter
//   Directed self-checking bench for hex_write_arbiter with default
//   parameters (3 requesters, 16-bit words, TIMEOUT 255, SKIP_SAME 1).
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_hex_write_arbiter;

    logic clk;
    logic reset;
    logic busy;
    logic err_timeout;

    int checks = 0;
    int errors = 0;

    hex_write_arbiter_if #(.NUM_REQ(3), .DATA_W(16)) bus ();

    hex_write_arbiter #(
        .NUM_REQ   (3),
        .DATA_W    (16),
        .TIMEOUT   (255),
        .SKIP_SAME (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the DUT locks up somewhere the directed steps do
    // not already bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [15:0] d0,
                                 input logic [15:0] d1, input logic [15:0] d2,
                                 input logic w);
        bus.req             = r;
        bus.req_data        = {d2, d1, d0};
        bus.avm_waitrequest = w;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // {address, chipselect, write_n, writedata} packed for one-shot compares.
    function automatic logic [63:0] bus_now();
        return {28'd0, bus.avm_address, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata};
    endfunction

    function automatic logic [63:0] bus_write(input logic [31:0] d);
        return {28'd0, 2'b00, 1'b1, 1'b0, d};
    endfunction

    function automatic logic [63:0] bus_idle();
        return {28'd0, 2'b00, 1'b0, 1'b1, 32'd0};
    endfunction

    logic [2:0]  exp_order [4];
    logic [15:0] exp_data  [4];
    int          stall_cycles;

    initial begin
        exp_order[0] = 3'b001; exp_data[0] = 16'hA000;
        exp_order[1] = 3'b010; exp_data[1] = 16'hB111;
        exp_order[2] = 3'b100; exp_data[2] = 16'hC222;
        exp_order[3] = 3'b001; exp_data[3] = 16'hA000;

        // ---- Reset state ----
        reset = 1'b1;
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput("reset_bus",  bus_now(), bus_idle());
        checkOutput("reset_ack",  64'(bus.ack), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_err",  64'(err_timeout), 64'd0);
        reset = 1'b0;
        tick();

        // ---- Single write from requester 0, no stall ----
        applyStimulus(3'b001, 16'h1234, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("single_c1_bus",  bus_now(), bus_write(32'h0000_1234));
        checkOutput("single_c1_busy", 64'(busy), 64'd1);
        checkOutput("single_c1_ack",  64'(bus.ack), 64'd0);
        tick();
        checkOutput("single_c2_ack",  64'(bus.ack), 64'b001);
        checkOutput("single_c2_bus",  bus_now(), bus_idle());
        applyStimulus(3'b000, 16'h1234, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("single_c3_ack",  64'(bus.ack), 64'd0);
        checkOutput("single_c3_busy", 64'(busy), 64'd0);

        // ---- Same word again: acknowledged without a bus cycle ----
        applyStimulus(3'b001, 16'h1234, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("skip_c1_ack", 64'(bus.ack), 64'b001);
        checkOutput("skip_c1_bus", bus_now(), bus_idle());
        applyStimulus(3'b000, 16'h1234, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("skip_c2_ack", 64'(bus.ack), 64'd0);

        // ---- All three requesting right after reset: order 0,1,2,0 ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(3'b111, 16'hA000, 16'hB111, 16'hC222, 1'b0);
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput($sformatf("rr%0d_bus", t), bus_now(), bus_write(32'(exp_data[t])));
            checkOutput($sformatf("rr%0d_wr_ack", t), 64'(bus.ack), 64'd0);
            tick();
            checkOutput($sformatf("rr%0d_ack", t), 64'(bus.ack), 64'(exp_order[t]));
            if (t == 3) begin
                applyStimulus(3'b000, 16'hA000, 16'hB111, 16'hC222, 1'b0);
            end
            tick();
            checkOutput($sformatf("rr%0d_idle_ack", t), 64'(bus.ack), 64'd0);
        end

        // ---- Three stalled cycles: bus stable for four cycles ----
        applyStimulus(3'b010, 16'h0, 16'h5555, 16'h0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput($sformatf("stall_c%0d_bus", c), bus_now(), bus_write(32'h0000_5555));
            checkOutput($sformatf("stall_c%0d_ack", c), 64'(bus.ack), 64'd0);
        end
        bus.avm_waitrequest = 1'b0;
        tick();
        checkOutput("stall_done_ack", 64'(bus.ack), 64'b010);
        checkOutput("stall_done_bus", bus_now(), bus_idle());
        applyStimulus(3'b000, 16'h0, 16'h5555, 16'h0, 1'b0);
        tick();

        // ---- Waitrequest stuck high: abort after 255 stalled cycles ----
        applyStimulus(3'b100, 16'h0, 16'h0, 16'h7777, 1'b1);
        tick();
        stall_cycles = 0;
        while ((bus.avm_chipselect === 1'b1) && (stall_cycles < 400)) begin
            stall_cycles++;
            tick();
        end
        checkOutput("timeout_cycles", 64'(stall_cycles), 64'd255);
        checkOutput("timeout_ack",    64'(bus.ack), 64'b100);
        checkOutput("timeout_err",    64'(err_timeout), 64'd1);
        checkOutput("timeout_bus",    bus_now(), bus_idle());
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h7777, 1'b0);
        tick();
        checkOutput("timeout_err_sticky", 64'(err_timeout), 64'd1);
        checkOutput("timeout_idle_ack",   64'(bus.ack), 64'd0);

        // Same word again must really go out, since the shadow was not updated.
        applyStimulus(3'b100, 16'h0, 16'h0, 16'h7777, 1'b0);
        tick();
        checkOutput("retry_bus", bus_now(), bus_write(32'h0000_7777));
        tick();
        checkOutput("retry_ack", 64'(bus.ack), 64'b100);
        checkOutput("retry_err", 64'(err_timeout), 64'd1);
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h7777, 1'b0);
        tick();

        // ---- Reset during a stalled write ----
        applyStimulus(3'b001, 16'h9999, 16'h0, 16'h0, 1'b1);
        tick();
        checkOutput("rst_mid_c1_bus", bus_now(), bus_write(32'h0000_9999));
        tick();
        checkOutput("rst_mid_c2_bus", bus_now(), bus_write(32'h0000_9999));
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_bus",  bus_now(), bus_idle());
        checkOutput("rst_mid_ack",  64'(bus.ack), 64'd0);
        checkOutput("rst_mid_err",  64'(err_timeout), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        applyStimulus(3'b000, 16'h9999, 16'h0, 16'h0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_after_ack", 64'(bus.ack), 64'd0);
        tick();
        checkOutput("rst_after_bus", bus_now(), bus_idle());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
